uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//   Parametrised UART receiver, successor to the fixed 8N1 receiver used by
//   the PUF host link. Supports configurable data width, 1 or 2 stop bits,
//   framing-error and break detection, and an optional parity check.
//   Sits between the board RX pin and the challenge/command decoder.
// PARAMETERS
//   CLKS_PER_BIT  87  i_Clock cycles per bit (Fclk/baud); legal range >= 4
//   DATA_BITS     8   payload bits per frame; legal range 5..9; sent LSB first
//   STOP_BITS     1   stop bits per frame; legal values 1 or 2
//   PARITY_ODD    0   used only with UART_RX_PARITY_EN; 0 = even, 1 = odd
// PORTS
//   i_Clock      in   1          sole clock; all logic on posedge
//   i_Reset      in   1          synchronous reset, active-high
//   i_Rx_Serial  in   1          asynchronous serial line; idles high
//   o_Rx_DV      out  1          1-cycle pulse: frame complete, outputs valid
//   o_Rx_Byte    out  DATA_BITS  received payload, held until next o_Rx_DV
//   o_Frame_Err  out  1          1-cycle pulse with o_Rx_DV: a stop bit read 0
//   o_Parity_Err out  1          1-cycle pulse with o_Rx_DV: parity mismatch
//   o_Busy       out  1          high in every state except IDLE
// BEHAVIOUR
//   - Input synchroniser: 2 flops, reset value 1. All sampling uses the
//     second flop, so there are 2 cycles of line latency.
//   - Counter width is $clog2(CLKS_PER_BIT). Bit index width is $clog2(DATA_BITS+1).
//   - Reset values: o_Rx_DV, o_Frame_Err, o_Parity_Err, o_Busy, o_Rx_Byte = 0;
//     state = IDLE. Reset in any state aborts the frame and produces no DV.
//   - States:
//     IDLE: on synced line = 0, go to START with the counter cleared.
//     START: at count (CLKS_PER_BIT-1)/2, sample the line.
//       If 0, clear the counter and go to DATA.
//       If 1, treat it as a glitch and return to IDLE with no outputs.
//     DATA: sample at count CLKS_PER_BIT-1, then clear the counter. Sample i
//       goes to shadow bit i. After DATA_BITS samples, go to PARITY if the
//       macro is defined, else go to STOP.
//     PARITY: sample 1 bit at the same spacing, then go to STOP.
//     STOP: take STOP_BITS samples at CLKS_PER_BIT-1 spacing. Any 0 sample
//       sets an internal frame-error flag.
//       After the final stop-bit sample, the next cycle does the following:
//       o_Rx_DV = 1; shadow is copied to o_Rx_Byte; error pulses are driven.
//       Then go to CLEANUP, or to BREAK_WAIT if a frame error occurred.
//     CLEANUP: 1 cycle, DV low, then go to IDLE.
//     BREAK_WAIT: hold until the synced line = 1, then go to IDLE.
//       This prevents a held-low line or break from retriggering frames.
//   - o_Rx_Byte changes only in the o_Rx_DV cycle. Partial frames never
//     appear on it.
//   - o_Rx_DV fires for every completed frame. Error frames still deliver
//     their data; the error pulses qualify the frame.
//   - Back-to-back frames: a start edge arriving during CLEANUP is caught
//     in IDLE on the next cycle. No frame is lost at 1 stop bit.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     - The PARITY state is present.
//     - Expected parity = XOR of the payload, XOR PARITY_ODD.
//     - o_Parity_Err pulses with o_Rx_DV on a mismatch.
//   UART_RX_PARITY_EN undefined:
//     - There is no PARITY state; frames are DATA_BITS-N-STOP_BITS.
//     - o_Parity_Err is tied to 0.
// TESTING  (CLKS_PER_BIT=16 unless noted)
//   1. 8N1, send 0xA5 -> o_Rx_DV pulses exactly once, o_Rx_Byte=0xA5,
//      o_Frame_Err=0; DV is ~8 cycles after the stop bit starts (mid-bit).
//   2. Low glitch of 4 cycles on an idle line -> no o_Rx_DV; o_Busy high then
//      back to 0; o_Rx_Byte keeps its previous value.
//   3. 0x3C sent with the stop bit driven 0, line held low for 5 bit times
//      -> DV with byte 0x3C and o_Frame_Err=1; no further DV until the line
//      rises; then 0x55 is received correctly.
//   4. Assert i_Reset mid-DATA while receiving 0xFF -> all outputs 0 on the
//      next cycle, no DV; a following 0x81 is received correctly.
//   5. DATA_BITS=5, STOP_BITS=2, send 0x15 then 0x0A back-to-back -> two DV
//      pulses, values 0x15 and 0x0A; a 0 in the 2nd stop bit gives o_Frame_Err.
//   6. UART_RX_PARITY_EN, PARITY_ODD=0, send 0x07 with parity 1 -> no error;
//      send 0x07 with parity 0 -> DV with o_Parity_Err=1, byte 0x07.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver for the PUF host link.
// Takes the asynchronous RX pin, re-times it through a two-flop synchroniser
// and decodes DATA_BITS-payload frames with STOP_BITS stop bits, LSB first.
// Each completed frame delivers its payload with a one-cycle o_Rx_DV pulse.
// A stop bit read as 0 raises o_Frame_Err with the pulse. After a framing
// error the receiver waits for the line to return high. This stops a break
// or a held-low line from producing further frames.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit after the
// payload. The parity is even when PARITY_ODD=0 and odd when PARITY_ODD=1.
// A parity mismatch is reported on o_Parity_Err.

module uart_rx_param #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID       = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        CLEANUP,
        BREAK_WAIT
    } state_t;

    state_t               state_q;
    logic                 rxMeta_q;
    logic                 rxSync_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shadow_q;
    logic                 frameErrFlag_q;
    logic                 rxDv_q;
    logic [DATA_BITS-1:0] rxByte_q;
    logic                 frameErr_q;
    logic                 busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 parityBit_q;
    logic                 parityErr_q;
`endif

    // Bring the asynchronous pin into the clock domain; idle-high reset value
    // keeps the receiver from seeing a false start bit coming out of reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= i_Rx_Serial;
            rxSync_q <= rxMeta_q;
        end
    end

    // Frame decoder: mid-bit sampling via the bit-period counter, payload
    // shifted in LSB first, outputs registered and pulsed for one cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            shadow_q       <= '0;
            frameErrFlag_q <= 1'b0;
            rxDv_q         <= 1'b0;
            rxByte_q       <= '0;
            frameErr_q     <= 1'b0;
            busy_q         <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBit_q    <= 1'b0;
            parityErr_q    <= 1'b0;
`endif
        end else begin
            rxDv_q     <= 1'b0;
            frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rxSync_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q <= '0;
                        if (!rxSync_q) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q    <= '0;
                        shadow_q <= {rxSync_q, shadow_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST_DATA) begin
                            idx_q          <= '0;
                            frameErrFlag_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state_q        <= PARITY;
`else
                            state_q        <= STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        parityBit_q <= rxSync_q;
                        state_q     <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST_STOP) begin
                            idx_q      <= '0;
                            rxDv_q     <= 1'b1;
                            rxByte_q   <= shadow_q;
                            frameErr_q <= frameErrFlag_q | ~rxSync_q;
`ifdef UART_RX_PARITY_EN
                            parityErr_q <= parityBit_q ^ (^shadow_q) ^ PARITY_ODD;
`endif
                            if (frameErrFlag_q | ~rxSync_q) begin
                                state_q <= BREAK_WAIT;
                            end else begin
                                state_q <= CLEANUP;
                            end
                        end else begin
                            idx_q          <= idx_q + 1'b1;
                            frameErrFlag_q <= frameErrFlag_q | ~rxSync_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CLEANUP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                BREAK_WAIT: begin
                    if (rxSync_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Rx_DV     = rxDv_q;
    assign o_Rx_Byte   = rxByte_q;
    assign o_Frame_Err = frameErr_q;
    assign o_Busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err = parityErr_q;
`else
    // Parity checking is compiled out. The odd/even selection has no effect.
    assign o_Parity_Err = PARITY_ODD & 1'b0;
`endif

endmodule
